mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, cycles waited for mem_ack before aborting (1..255).
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
 clk  in  1  single clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 c_req  in  1  CPU access request (controller ReadReq or WenMem)
 c_we  in  1  CPU write enable
 c_addr  in  32  CPU byte address
 c_wdata  in  32  CPU write data
 c_strb  in  3  CPU MemStrb size/sign code, passed through unchanged
 c_valid  out  1  CPU completion pulse (controller DataValid)
 l_req  in  1  loader/debug access request
 l_we  in  1  loader write enable
 l_addr  in  32  loader byte address
 l_wdata  in  32  loader write data
 l_strb  in  3  loader strobe code
 l_valid  out  1  loader completion pulse
 rdata  out  32  read data for the completing requester
 err  out  1  completion was a timeout abort
 mem_req  out  1  memory request, held until ack or abort
 mem_we, mem_addr, mem_wdata, mem_strb  out  1/32/32/3  muxed request fields
 mem_ack  in  1  memory completion, 1-cycle pulse
 mem_rdata  in  32  memory read data, valid with mem_ack

Function
REQ-003 SHALL implement FSM states IDLE, BUSY; one outstanding access.
REQ-004 IDLE: if any req sampled high at edge N, SHALL latch the winner's we/addr/wdata/strb, enter BUSY, and assert mem_req from cycle N+1.
REQ-005 Arbitration SHALL be round-robin: with both requests pending, grant goes to the requester not granted last; last-grant pointer resets to loader, so CPU wins the first tie.
REQ-006 A lone requester SHALL be granted regardless of the pointer; the pointer updates on every grant.
REQ-007 mem_* fields SHALL come from the latched copy and stay stable while mem_req=1; requester input changes during BUSY SHALL be ignored.
REQ-008 BUSY: on mem_ack, SHALL deassert mem_req next cycle, register rdata=mem_rdata (reads) or 0 (writes), err=0, pulse the owner's *_valid for exactly one cycle, return to IDLE.
REQ-009 Latency: grant edge to earliest valid pulse SHALL be 2 cycles (mem_ack in first mem_req cycle); a new grant SHALL be possible the cycle valid is high.
REQ-010 SHALL count BUSY cycles with an 8-bit counter; when it reaches TIMEOUT with no ack, SHALL deassert mem_req, pulse owner's *_valid with err=1, rdata=0, return to IDLE.
REQ-011 mem_ack arriving in IDLE (late/stray) SHALL be ignored; no valid pulse.
REQ-012 mem_ack in the timeout cycle SHALL take precedence: normal completion, err=0.
REQ-013 Requesters hold req until their valid; a req dropped before grant SHALL simply not be granted.
REQ-014 c_valid and l_valid SHALL never be high together; rdata/err SHALL hold their values until the next completion.

Reset
REQ-015 On reset: state IDLE, mem_req=0, c_valid=0, l_valid=0, err=0, rdata=0, counter=0, pointer=loader, latched fields 0.
REQ-016 Reset mid-BUSY SHALL abort silently: mem_req low the next cycle, no valid pulse; an ack arriving afterwards is handled per REQ-011.

Structure
REQ-017 FSM state encodings and requester IDs SHALL live in the shared CPU package; TIMEOUT stays a module parameter.
REQ-018 SHALL be flat, no sub-modules; it sits between CONTROLLER/datapath and memory, driving DataValid.

Verification
REQ-019 CPU read alone, addr 0x100, ack 3 cycles later with 0xDEADBEEF -> one c_valid pulse, rdata=0xDEADBEEF, err=0.
REQ-020 c_req and l_req high in the same cycle after reset -> CPU granted first, loader next; mem_addr order matches.
REQ-021 Loader writes 0x0 then 0x4 back-to-back while CPU idle -> two grants, mem_we=1, mem_wdata matches, two l_valid pulses.
REQ-022 TIMEOUT=4, mem_ack never asserted -> mem_req high 4 cycles, then valid with err=1, rdata=0.
REQ-023 reset asserted 2 cycles into BUSY, then stray mem_ack -> mem_req=0, no valid pulse, FSM IDLE.
REQ-024 mem_ack in the exact timeout cycle -> normal completion, err=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester
// IDs, the latched request record and the round-robin pick function.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU    = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    // One memory access as presented to the memory port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  strb;
    } mem_cmd_t;

    // A lone requester always wins; on a tie the requester that was not
    // granted last wins. With no request at all the result is unused.
    function automatic req_id_t pick_winner(input logic    cpu_req,
                                            input logic    ldr_req,
                                            input req_id_t last_grant);
        if (cpu_req && ldr_req) begin
            return (last_grant == REQ_CPU) ? REQ_LOADER : REQ_CPU;
        end else if (ldr_req) begin
            return REQ_LOADER;
        end else begin
            return REQ_CPU;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (CPU datapath and loader/debug port) in front
// of a single-outstanding memory. Round-robin grant, latched request fields,
// registered completion pulses and an 8-bit BUSY timeout that aborts an
// access whose ack never arrives.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [2:0]  c_strb,
    output logic        c_valid,
    // loader side
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic [2:0]  l_strb,
    output logic        l_valid,
    // completion data shared by both requesters
    output logic [31:0] rdata,
    output logic        err,
    // memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_strb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_t  r_state;
    req_id_t     r_last_grant;   // also the owner of the access in flight
    mem_cmd_t    r_cmd;
    logic [7:0]  r_busy_cnt;
    logic        r_mem_req;
    logic        r_c_valid;
    logic        r_l_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    req_id_t     w_winner;
    mem_cmd_t    w_sel_cmd;
    logic [7:0]  w_cnt_next;

    assign w_any_req  = c_req | l_req;
    assign w_cnt_next = r_busy_cnt + 8'd1;

    // Pick the grant winner and mux its request fields.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block can leave it unassigned and infer a latch.
        w_winner  = pick_winner(c_req, l_req, r_last_grant);
        w_sel_cmd = '{we: c_we, addr: c_addr, wdata: c_wdata, strb: c_strb};
        if (w_winner == REQ_LOADER) begin
            w_sel_cmd = '{we: l_we, addr: l_addr, wdata: l_wdata, strb: l_strb};
        end
    end

    // Arbiter FSM: grant in IDLE, wait for ack or timeout in BUSY.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= REQ_LOADER;
            r_cmd        <= '0;
            r_busy_cnt   <= 8'd0;
            r_mem_req    <= 1'b0;
            r_c_valid    <= 1'b0;
            r_l_valid    <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            r_c_valid <= 1'b0;
            r_l_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A stray mem_ack here is deliberately ignored.
                    r_busy_cnt <= 8'd0;
                    if (w_any_req) begin
                        r_cmd        <= w_sel_cmd;
                        r_last_grant <= w_winner;
                        r_mem_req    <= 1'b1;
                        r_state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (mem_ack) begin
                        // Ack wins even in the cycle the timeout would fire.
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_cmd.we ? 32'd0 : mem_rdata;
                        r_err     <= 1'b0;
                        r_c_valid <= (r_last_grant == REQ_CPU);
                        r_l_valid <= (r_last_grant == REQ_LOADER);
                        r_state   <= ST_IDLE;
                    end else if (w_cnt_next == TIMEOUT_CNT) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= 32'd0;
                        r_err     <= 1'b1;
                        r_c_valid <= (r_last_grant == REQ_CPU);
                        r_l_valid <= (r_last_grant == REQ_LOADER);
                        r_state   <= ST_IDLE;
                    end else begin
                        r_busy_cnt <= w_cnt_next;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign c_valid   = r_c_valid;
    assign l_valid   = r_l_valid;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_cmd.we;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign mem_strb  = r_cmd.strb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Expected grants and completions are
// pushed to queues when a request is issued; a per-cycle observer (sampling
// on the falling edge) pops and compares them, models the memory and checks
// field stability, valid exclusivity and grant spacing.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [2:0]  c_strb, l_strb;
    logic        c_valid, l_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_strb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_strb(c_strb), .c_valid(c_valid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_strb(l_strb), .l_valid(l_valid),
        .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_cpu;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  strb;
        int          delay;   // ack after this many mem_req cycles, <0 never
        int          gap;     // cycles since last valid, <0 don't care
    } grant_t;

    typedef struct {
        logic        is_cpu;
        logic [31:0] rdata;
        logic        err;
        int          cycles;  // cycles mem_req stays high
    } done_t;

    grant_t      gq[$];
    done_t       dq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          last_valid_cycle = -100;
    int          req_cycles = 0;
    int          cur_delay  = -1;
    logic        prev_mem_req   = 1'b0;
    logic        abort_expected = 1'b0;
    logic        stray_pending  = 1'b0;
    logic [31:0] held_addr;
    logic [35:0] held_rest;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Memory contents model.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic observe();
        grant_t g;
        done_t  d;
        logic   any_valid;
        any_valid = c_valid | l_valid;

        if (c_valid && l_valid) check("valid_exclusive", 64'(1), 64'(0));

        if (any_valid) begin
            last_valid_cycle = cycle;
            check("mem_req_low_at_valid", 64'(mem_req), 64'(0));
            if (dq.size() == 0) begin
                check("unexpected_valid", 64'({c_valid, l_valid}), 64'(0));
            end else begin
                d = dq.pop_front();
                check("valid_owner", 64'({c_valid, l_valid}), 64'(d.is_cpu ? 2'b10 : 2'b01));
                check("rdata", 64'(rdata), 64'(d.rdata));
                check("err", 64'(err), 64'(d.err));
                check("mem_req_cycles", 64'(req_cycles), 64'(d.cycles));
            end
        end

        if (prev_mem_req && !mem_req) begin
            if (abort_expected) begin
                check("silent_abort", 64'(any_valid), 64'(0));
                abort_expected = 1'b0;
            end else begin
                check("valid_on_drop", 64'(any_valid), 64'(1));
            end
        end

        if (mem_req && !prev_mem_req) begin
            req_cycles = 0;
            if (gq.size() == 0) begin
                check("spurious_grant", 64'(1), 64'(0));
                cur_delay = -1;
            end else begin
                g = gq.pop_front();
                check("grant_we", 64'(mem_we), 64'(g.we));
                check("grant_addr", 64'(mem_addr), 64'(g.addr));
                check("grant_wdata", 64'(mem_wdata), 64'(g.wdata));
                check("grant_strb", 64'(mem_strb), 64'(g.strb));
                if (g.gap >= 0) check("grant_gap", 64'(cycle - last_valid_cycle), 64'(g.gap));
                cur_delay = g.delay;
                if (g.is_cpu) c_req = 1'b0;
                else          l_req = 1'b0;
            end
            held_addr = mem_addr;
            held_rest = {mem_we, mem_wdata, mem_strb};
        end else if (mem_req) begin
            check("hold_addr", 64'(mem_addr), 64'(held_addr));
            check("hold_fields", 64'({mem_we, mem_wdata, mem_strb}), 64'(held_rest));
        end

        if (mem_req) req_cycles++;

        // Memory model: drive ack/rdata for the coming cycle.
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (stray_pending) begin
            mem_ack       = 1'b1;
            mem_rdata     = 32'hBAD0_BAD0;
            stray_pending = 1'b0;
        end else if (mem_req && cur_delay == req_cycles - 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_of(mem_addr);
        end
        prev_mem_req = mem_req;
    endtask

    // Idle requesters wiggle their fields; the arbiter must not care.
    task automatic scramble();
        if (!c_req) begin
            c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom; c_strb = 3'($urandom);
        end
        if (!l_req) begin
            l_we = 1'($urandom); l_addr = $urandom; l_wdata = $urandom; l_strb = 3'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle++;
        observe();
        scramble();
    endtask

    task automatic issue(input logic is_cpu, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] strb,
                         input int delay, input int gap, input bit expect_done);
        grant_t g;
        done_t  d;
        bit     tmo;
        tmo     = (delay < 0) || (delay >= TMO);
        g.is_cpu = is_cpu; g.we = we; g.addr = addr; g.wdata = wdata; g.strb = strb;
        g.delay  = delay;  g.gap = gap;
        gq.push_back(g);
        if (expect_done) begin
            d.is_cpu = is_cpu;
            d.err    = tmo;
            d.rdata  = (tmo || we) ? 32'h0 : rd_of(addr);
            d.cycles = tmo ? TMO : delay + 1;
            dq.push_back(d);
        end
        if (is_cpu) begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_strb = strb;
        end else begin
            l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; l_strb = strb;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((gq.size() != 0 || dq.size() != 0 || mem_req) && n < budget) begin
            tick();
            n++;
        end
        if (gq.size() != 0 || dq.size() != 0) begin
            check("drain_timeout", 64'(gq.size() + dq.size()), 64'(0));
            gq.delete();
            dq.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_strb = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_strb = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_c_valid", 64'(c_valid), 64'(0));
        check("rst_l_valid", 64'(l_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_fields", 64'({mem_we, mem_addr, mem_strb}), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        reset = 1'b0;
        prev_mem_req = mem_req;

        // Tie right after reset: CPU first, loader immediately after.
        issue(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 0, -1, 1'b1);
        issue(1'b0, 1'b0, 32'h300, 32'h0, 3'b010, 1,  1, 1'b1);
        wait_idle(30);

        // Lone CPU read, ack in the third mem_req cycle.
        issue(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 2, -1, 1'b1);
        wait_idle(30);
        repeat (3) tick();
        check("rdata_hold", 64'(rdata), 64'(32'hDEADBEEF));

        // CPU write with the fastest ack: rdata must read back as zero.
        issue(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 3'b000, 0, -1, 1'b1);
        wait_idle(30);

        // Tie with CPU granted last: loader goes first this time.
        issue(1'b0, 1'b1, 32'h400, 32'h1234_5678, 3'b001, 0, -1, 1'b1);
        issue(1'b1, 1'b0, 32'h500, 32'h0,         3'b100, 0,  1, 1'b1);
        wait_idle(30);

        // Loader back-to-back writes to 0x0 and 0x4.
        issue(1'b0, 1'b1, 32'h0, 32'h1111_1111, 3'b010, 0, -1, 1'b1);
        begin
            int n = 0;
            do begin tick(); n++; end while (!l_valid && n < 20);
            check("b2b_first_valid", 64'(l_valid), 64'(1));
        end
        issue(1'b0, 1'b1, 32'h4, 32'h2222_2222, 3'b010, 0, 1, 1'b1);
        wait_idle(30);

        // Stray ack while idle produces nothing.
        stray_pending = 1'b1;
        tick();
        tick();
        check("stray_no_valid", 64'({c_valid, l_valid}), 64'(0));
        check("stray_no_req", 64'(mem_req), 64'(0));

        // Ack never comes: timeout abort with err=1, rdata=0, then held.
        issue(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, -1, -1, 1'b1);
        wait_idle(30);
        repeat (2) tick();
        check("err_hold", 64'(err), 64'(1));
        check("err_rdata_zero", 64'(rdata), 64'(0));

        // Ack in the exact timeout cycle completes normally.
        issue(1'b0, 1'b0, 32'h80, 32'h0, 3'b010, TMO - 1, -1, 1'b1);
        wait_idle(30);

        // Loader pulses req while CPU is busy and drops it: never granted.
        issue(1'b1, 1'b0, 32'h600, 32'h0, 3'b010, 1, -1, 1'b1);
        tick();
        l_req = 1'b1;
        tick();
        l_req = 1'b0;
        wait_idle(30);
        repeat (3) tick();
        check("dropped_req_no_grant", 64'(mem_req), 64'(0));

        // Reset two cycles into BUSY, then a stray ack.
        issue(1'b1, 1'b0, 32'h700, 32'h0, 3'b010, -1, -1, 1'b0);
        tick();
        tick();
        check("busy_before_reset", 64'(mem_req), 64'(1));
        reset = 1'b1;
        abort_expected = 1'b1;
        tick();
        check("reset_abort_req", 64'(mem_req), 64'(0));
        reset = 1'b0;
        stray_pending = 1'b1;
        tick();
        tick();
        tick();
        check("post_reset_req", 64'(mem_req), 64'(0));
        check("post_reset_valid", 64'({c_valid, l_valid}), 64'(0));
        check("post_reset_err", 64'(err), 64'(0));

        // Pointer is back at loader after reset: CPU wins the tie again.
        issue(1'b1, 1'b0, 32'h800, 32'h0, 3'b010, 0, -1, 1'b1);
        issue(1'b0, 1'b0, 32'h900, 32'h0, 3'b010, 0,  1, 1'b1);
        wait_idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
